// File: rtl/calc_acc_if.sv
// Entry/result bus of the serial calculator. clk and rst stay plain ports on the block.
interface calc_acc_if #(
  parameter int WIDTH = 8
);
  logic             validIn;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             ovf;
  logic             err;
  logic             busy;
  logic             done;

  // Keypad/debouncer side: drives entries, observes results.
  modport master (
    output validIn, dataIn,
    input  dataOut, ovf, err, busy, done
  );

  // Calculator side.
  modport slave (
    input  validIn, dataIn,
    output dataOut, ovf, err, busy, done
  );
endinterface

// File: rtl/calc_acc.sv
// Serial calculator with width parameter, overflow/error flags, iterative divide/modulo
// and optional accumulator chaining. One entry per rising edge of the debounced validIn.
//
// state  | meaning
// S_NUM1 | waiting for first operand
// S_OP   | waiting for opcode (num1 valid)
// S_NUM2 | waiting for second operand of a binary op
// S_DIV  | restoring divider running, busy high
//
// The interface instance must carry the same WIDTH as this module.
module calc_acc #(
  parameter int WIDTH = 8,
  parameter int CHAIN = 0
) (
  input logic       clk,
  input logic       rst,
  calc_acc_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MUL = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SQR = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_MOD = 4'd7;
  localparam logic [3:0] OP_CLR = 4'd8;

  typedef enum logic [1:0] {S_NUM1, S_OP, S_NUM2, S_DIV} state_t;

  state_t           state;
  logic [WIDTH-1:0] num1;
  logic [3:0]       op;
  logic             valid_dly;
  logic [WIDTH-1:0] data_out;
  logic             ovf_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  assign bus.dataOut = data_out;
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  logic             valid;
  logic [3:0]       opc;
  logic [2*WIDTH-1:0] prod_mul;
  logic [2*WIDTH-1:0] prod_sqr;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             din_zero;

  // Edge-detected entry strobe and shared arithmetic datapath.
  always_comb begin
    valid    = bus.validIn & ~valid_dly & ~busy_q;
    opc      = bus.dataIn[3:0];
    din_zero = (bus.dataIn == '0);
    prod_mul = {{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, bus.dataIn};
    prod_sqr = {{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, num1};
    sum      = {1'b0, num1} + {1'b0, bus.dataIn};
    diff     = {1'b0, num1} - {1'b0, bus.dataIn};
    inc      = {1'b0, num1} + (WIDTH+1)'(1);
    dec      = num1 - WIDTH'(1);
    // Remainder never reaches the divisor, so the borrow bit of the trial
    // subtraction alone tells whether the divisor fits.
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    fits     = ~trial[WIDTH];
    rem_nxt  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], fits};
  end

  logic             res_fire;
  logic [WIDTH-1:0] res_val;
  logic             res_ovf;
  logic             res_err;
  logic             start_div;

  // Result completion: every path that ends in a done pulse funnels through here.
  always_comb begin
    res_fire  = 1'b0;
    res_val   = '0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    start_div = 1'b0;
    if (state == S_DIV) begin
      if (cnt == CW'(1)) begin
        res_fire = 1'b1;
        res_val  = (op == OP_MOD) ? rem_nxt : quo_nxt;
      end
    end else if (valid) begin
      if (state == S_OP) begin
        case (opc)
          OP_SQR: begin
            res_fire = 1'b1;
            res_val  = prod_sqr[WIDTH-1:0];
            res_ovf  = |prod_sqr[2*WIDTH-1:WIDTH];
          end
          OP_INC: begin
            res_fire = 1'b1;
            res_val  = inc[WIDTH-1:0];
            res_ovf  = inc[WIDTH];
          end
          OP_DEC: begin
            res_fire = 1'b1;
            res_val  = dec;
            res_ovf  = (num1 == '0);
          end
          default: ;
        endcase
      end else if (state == S_NUM2) begin
        case (op)
          OP_MUL: begin
            res_fire = 1'b1;
            res_val  = prod_mul[WIDTH-1:0];
            res_ovf  = |prod_mul[2*WIDTH-1:WIDTH];
          end
          OP_ADD: begin
            res_fire = 1'b1;
            res_val  = sum[WIDTH-1:0];
            res_ovf  = sum[WIDTH];
          end
          OP_SUB: begin
            res_fire = 1'b1;
            res_val  = diff[WIDTH-1:0];
            res_ovf  = diff[WIDTH];
          end
          OP_DIV: begin
            if (din_zero) begin
              res_fire = 1'b1;
              res_val  = '1;
              res_err  = 1'b1;
            end else begin
              start_div = 1'b1;
            end
          end
          default: begin
            if (din_zero) begin
              res_fire = 1'b1;
              res_val  = num1;
              res_err  = 1'b1;
            end else begin
              start_div = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Sequencer: state, operands, divider and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_NUM1;
      num1      <= '0;
      op        <= '0;
      valid_dly <= 1'b0;
      data_out  <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      valid_dly <= bus.validIn;
      done_q    <= 1'b0;
      if (res_fire) begin
        data_out <= res_val;
        ovf_q    <= res_ovf;
        err_q    <= res_err;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        if (CHAIN != 0) begin
          num1  <= res_val;
          state <= S_OP;
        end else begin
          state <= S_NUM1;
        end
      end else begin
        case (state)
          S_NUM1: begin
            if (valid) begin
              num1     <= bus.dataIn;
              data_out <= bus.dataIn;
              ovf_q    <= 1'b0;
              err_q    <= 1'b0;
              state    <= S_OP;
            end
          end
          S_OP: begin
            if (valid) begin
              case (opc)
                OP_MUL, OP_ADD, OP_SUB, OP_DIV, OP_MOD: begin
                  op       <= opc;
                  data_out <= bus.dataIn;
                  ovf_q    <= 1'b0;
                  err_q    <= 1'b0;
                  state    <= S_NUM2;
                end
                OP_CLR: begin
                  num1     <= '0;
                  data_out <= '0;
                  ovf_q    <= 1'b0;
                  err_q    <= 1'b0;
                  state    <= S_NUM1;
                end
                OP_SQR, OP_INC, OP_DEC: ;
                default: begin
                  data_out <= bus.dataIn;
                  ovf_q    <= 1'b0;
                  err_q    <= 1'b1;
                end
              endcase
            end
          end
          S_NUM2: begin
            if (start_div) begin
              divisor <= bus.dataIn;
              rem     <= '0;
              quo     <= num1;
              cnt     <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state   <= S_DIV;
            end
          end
          default: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_acc.sv
// Randomised and directed checks of calc_acc (CHAIN=0 and CHAIN=1 instances)
// against an arithmetic reference model of the calculator.
module tb_calc_acc;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         vin     [2];
  logic [W-1:0] din     [2];
  logic [W-1:0] dout    [2];
  logic         ovf_o   [2];
  logic         err_o   [2];
  logic         busy_o  [2];
  logic         done_o  [2];

  calc_acc_if #(.WIDTH(W)) bus0 ();
  calc_acc_if #(.WIDTH(W)) bus1 ();

  assign bus0.validIn = vin[0];
  assign bus0.dataIn  = din[0];
  assign bus1.validIn = vin[1];
  assign bus1.dataIn  = din[1];
  assign dout[0]   = bus0.dataOut;
  assign ovf_o[0]  = bus0.ovf;
  assign err_o[0]  = bus0.err;
  assign busy_o[0] = bus0.busy;
  assign done_o[0] = bus0.done;
  assign dout[1]   = bus1.dataOut;
  assign ovf_o[1]  = bus1.ovf;
  assign err_o[1]  = bus1.err;
  assign busy_o[1] = bus1.busy;
  assign done_o[1] = bus1.done;

  calc_acc #(.WIDTH(W), .CHAIN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  calc_acc #(.WIDTH(W), .CHAIN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 = expects first operand, 1 = expects opcode, 2 = expects second operand.
  int m_phase [2];
  int m_num1  [2];
  int m_op    [2];
  int m_out   [2];
  int m_ovf   [2];
  int m_err   [2];

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_num1[d] = 0; m_op[d] = 0;
      m_out[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
    end
  endfunction

  function automatic void m_result(int d, int r, int o, int e);
    m_out[d] = r & MASK;
    m_ovf[d] = o;
    m_err[d] = e;
    if (d == 1) begin
      m_num1[d]  = r & MASK;
      m_phase[d] = 1;
    end else begin
      m_phase[d] = 0;
    end
  endfunction

  // Returns 0: display update without done, 1: immediate result, 2: division result after busy.
  function automatic int m_apply(int d, int v);
    int a;
    int opc;
    a   = m_num1[d];
    opc = v & 15;
    if (m_phase[d] == 0) begin
      m_num1[d] = v; m_out[d] = v; m_ovf[d] = 0; m_err[d] = 0; m_phase[d] = 1;
      return 0;
    end
    if (m_phase[d] == 1) begin
      if (opc inside {0, 1, 2, 6, 7}) begin
        m_op[d] = opc; m_out[d] = v; m_ovf[d] = 0; m_err[d] = 0; m_phase[d] = 2;
        return 0;
      end
      if (opc == 3) begin m_result(d, a * a, int'(a * a > MASK), 0); return 1; end
      if (opc == 4) begin m_result(d, a + 1, int'(a == MASK), 0); return 1; end
      if (opc == 5) begin m_result(d, a - 1, int'(a == 0), 0); return 1; end
      if (opc == 8) begin
        m_num1[d] = 0; m_out[d] = 0; m_ovf[d] = 0; m_err[d] = 0; m_phase[d] = 0;
        return 0;
      end
      m_out[d] = v; m_ovf[d] = 0; m_err[d] = 1;
      return 0;
    end
    case (m_op[d])
      0: begin m_result(d, a * v, int'(a * v > MASK), 0); return 1; end
      1: begin m_result(d, a + v, int'(a + v > MASK), 0); return 1; end
      2: begin m_result(d, a - v, int'(a < v), 0); return 1; end
      6: begin
        if (v == 0) begin m_result(d, MASK, 0, 1); return 1; end
        m_result(d, a / v, 0, 0); return 2;
      end
      default: begin
        if (v == 0) begin m_result(d, a, 0, 1); return 1; end
        m_result(d, a % v, 0, 0); return 2;
      end
    endcase
  endfunction

  // One entry on instance d; validIn stays high for hold extra cycles.
  task automatic enter(input int d, input int v, input int hold);
    int kind;
    int prev_out;
    @(negedge clk);
    din[d]   = v[W-1:0];
    vin[d]   = 1'b1;
    prev_out = m_out[d];
    kind     = m_apply(d, v & MASK);
    @(negedge clk);
    if (kind == 2) begin
      for (int k = 0; k < W; k++) begin
        chk("div_busy", busy_o[d], 1);
        chk("div_no_done", done_o[d], 0);
        chk("div_out_hold", dout[d], prev_out);
        if (k == 1) vin[d] = 1'b0;
        if (k == 2) begin din[d] = W'($urandom); vin[d] = 1'b1; end
        if (k == 3) vin[d] = 1'b0;
        @(negedge clk);
      end
      chk("div_done", done_o[d], 1);
      chk("div_busy_clr", busy_o[d], 0);
      chk("div_out", dout[d], m_out[d]);
      chk("div_ovf", ovf_o[d], m_ovf[d]);
      chk("div_err", err_o[d], m_err[d]);
      @(negedge clk);
      chk("div_done_pulse", done_o[d], 0);
    end else begin
      chk("out", dout[d], m_out[d]);
      chk("ovf", ovf_o[d], m_ovf[d]);
      chk("err", err_o[d], m_err[d]);
      chk("done", done_o[d], (kind == 1) ? 1 : 0);
      chk("busy", busy_o[d], 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_done", done_o[d], 0);
        chk("hold_out", dout[d], m_out[d]);
      end
      vin[d] = 1'b0;
    end
  endtask

  function automatic int rand_entry(int d);
    int opc;
    if (m_phase[d] == 1) begin
      opc = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 8) : $urandom_range(9, 15);
      return (($urandom_range(0, 15) << 4) | opc) & MASK;
    end
    if (m_phase[d] == 2)
      return ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
    case ($urandom_range(0, 5))
      0: return 0;
      1: return MASK;
      default: return $urandom_range(0, MASK);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    vin[0] = 1'b0; vin[1] = 1'b0;
    din[0] = '0;   din[1] = '0;
    m_reset();
    #23;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out", dout[d], 0);
      chk("rst_ovf", ovf_o[d], 0);
      chk("rst_err", err_o[d], 0);
      chk("rst_busy", busy_o[d], 0);
      chk("rst_done", done_o[d], 0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed, non-chained
    enter(0, 7, 0);   enter(0, 3, 0);
    chk("sqr_49", dout[0], 49);
    enter(0, 200, 0); enter(0, 1, 0); enter(0, 100, 0);
    chk("add_44", dout[0], 44);
    chk("add_carry", ovf_o[0], 1);
    enter(0, 255, 0); enter(0, 4, 0);
    chk("inc_wrap", dout[0], 0);
    chk("inc_ovf", ovf_o[0], 1);
    enter(0, 100, 0); enter(0, 6, 0); enter(0, 7, 0);
    chk("div_14", dout[0], 14);
    enter(0, 100, 0); enter(0, 7, 0); enter(0, 7, 0);
    chk("mod_2", dout[0], 2);
    enter(0, 9, 0); enter(0, 6, 0); enter(0, 0, 0);
    chk("div0_val", dout[0], 255);
    chk("div0_err", err_o[0], 1);
    enter(0, 9, 0); enter(0, 12, 0);
    chk("illegal_echo", dout[0], 12);
    chk("illegal_err", err_o[0], 1);
    enter(0, 4, 0);
    chk("after_illegal_inc", dout[0], 10);
    enter(0, 50, 20); enter(0, 1, 3); enter(0, 5, 0);
    chk("held_single_entry", dout[0], 55);
    enter(0, 3, 0); enter(0, 2, 0); enter(0, 5, 0);
    chk("sub_borrow_val", dout[0], 254);
    chk("sub_borrow_ovf", ovf_o[0], 1);

    // Directed, chained
    enter(1, 5, 0); enter(1, 4, 0);
    chk("chain_inc", dout[1], 6);
    enter(1, 3, 0);
    chk("chain_sqr", dout[1], 36);
    enter(1, 8, 0);
    chk("chain_clr", dout[1], 0);
    enter(1, 21, 0); enter(1, 5, 0);
    chk("chain_after_clr", dout[1], 20);
    enter(1, 6, 0); enter(1, 3, 0);
    chk("chain_div", dout[1], 6);

    // Reset in the middle of a division
    enter(0, 100, 0); enter(0, 6, 0);
    @(negedge clk);
    din[0] = W'(5);
    vin[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy_o[0], 1);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_out", dout[d], 0);
      chk("mid_rst_busy", busy_o[d], 0);
      chk("mid_rst_done", done_o[d], 0);
      chk("mid_rst_flags", {ovf_o[d], err_o[d]}, 0);
    end
    m_reset();
    vin[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", done_o[0], 0);
      chk("post_rst_no_busy", busy_o[0], 0);
    end
    enter(0, 33, 0); enter(0, 4, 0);
    chk("post_rst_inc", dout[0], 34);

    // Randomised
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        enter(d, rand_entry(d), $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
